alu_pipe: RTL and testbench

Parametrised, pipelined successor of the 4-bit combinational ALU: same `op_a`/`op_b`/`inst` → `alu_out` semantics, generalised to `WIDTH` bits.

- Adds a two-stage registered pipeline with valid/ready handshakes on both sides.
- Adds status flags, a persistent carry register for multi-word add/subtract chains, and shifts.
- Sits between the operand/decode logic and the writeback path of the datapath.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_core.sv | 101 ++++++++++
 rtl/alu_pipe.sv | 86 ++++++++
 tb/tb_alu_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
// Used by alu_core and alu_pipe (optional saturation: ALU_SAT_EN).
package alu_pkg;

    localparam int INST_W         = 4;
    localparam int INST_CLASS_BIT = 3;
    localparam int INST_INV_BIT   = 2;

    localparam logic [1:0] LOGIC_PASS = 2'b00;
    localparam logic [1:0] LOGIC_OR   = 2'b01;
    localparam logic [1:0] LOGIC_AND  = 2'b10;
    localparam logic [1:0] LOGIC_XOR  = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_CLC = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ADD/SUB/ADC/SBC are the arithmetic ops with bit 2 clear; they reload the carry register.
    function automatic logic loads_creg(input logic [INST_W-1:0] inst);
        return inst[INST_CLASS_BIT] && !inst[2];
    endfunction

    function automatic logic clears_creg(input logic [INST_W-1:0] inst);
        return inst[INST_CLASS_BIT] && (inst[2:0] == OP_CLC);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {Z,N,C,V} from A, B, inst and the carry register.
// Define ALU_SAT_EN to saturate ADD/ADC on carry-out and SUB/SBC on borrow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [INST_W-1:0] inst,
    input  logic              creg,
    output logic [WIDTH-1:0]  result,
    output logic [3:0]        flags
);

    // One bit above the clog2 range so that amounts >= WIDTH are representable and clamp.
    localparam int              SHW      = $clog2(WIDTH) + 1;
    localparam logic [SHW-1:0]  SH_LIMIT = SHW'(WIDTH);

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH:0] s);
`ifdef ALU_SAT_EN
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH:0] d);
`ifdef ALU_SAT_EN
        return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
`else
        return d[WIDTH-1:0];
`endif
    endfunction

    logic [SHW-1:0]          sh;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH:0]          a_ext;
    logic [WIDTH:0]          b_ext;
    logic [WIDTH:0]          cin_ext;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [WIDTH-1:0]        res;
    logic                    c;
    logic                    v;

    assign sh      = b[SHW-1:0];
    assign a_s     = a;
    assign sra_res = a_s >>> sh;
    assign a_ext   = {1'b0, a};
    assign b_ext   = {1'b0, b};
    // ADC/SBC are the only ops with inst[1] set on the add/subtract path.
    assign cin_ext = {{WIDTH{1'b0}}, inst[1] & creg};
    assign sum     = a_ext + b_ext + cin_ext;
    assign diff    = a_ext - b_ext - cin_ext;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        if (!inst[INST_CLASS_BIT]) begin
            unique case (inst[1:0])
                LOGIC_PASS: res = a;
                LOGIC_OR:   res = a | b;
                LOGIC_AND:  res = a & b;
                LOGIC_XOR:  res = a ^ b;
                default:    res = a;
            endcase
            if (inst[INST_INV_BIT]) res = ~res;
        end else begin
            unique case (inst[2:0])
                OP_ADD, OP_ADC: begin
                    res = sat_add(sum);
                    c   = sum[WIDTH];
                    v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB, OP_SBC: begin
                    res = sat_sub(diff);
                    c   = diff[WIDTH];
                    v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SHL:  res = (sh >= SH_LIMIT) ? '0 : (a << sh);
                OP_SHR:  res = (sh >= SH_LIMIT) ? '0 : (a >> sh);
                OP_SRA:  res = (sh >= SH_LIMIT) ? {WIDTH{a[WIDTH-1]}} : sra_res;
                default: res = '0;
            endcase
        end
    end

    assign result = res;

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_N] = res[WIDTH-1];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with status flags and a carry register for chained ADC/SBC.
// Build option: define ALU_SAT_EN for saturating add/subtract (handled in alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  alu_out,
    output logic [3:0]        flags
);

    logic              vld_p1;
    logic              vld_p2;
    logic [WIDTH-1:0]  a_p1;
    logic [WIDTH-1:0]  b_p1;
    logic [INST_W-1:0] inst_p1;
    logic              creg;
    logic              s1_adv;
    logic              s2_adv;
    logic [WIDTH-1:0]  core_res;
    logic [3:0]        core_flags;

    assign s2_adv    = !vld_p2 || out_ready;
    assign s1_adv    = !vld_p1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;

    // Stage 1: operand/instruction capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            a_p1    <= op_a;
            b_p1    <= op_b;
            inst_p1 <= inst;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a_p1),
        .b      (b_p1),
        .inst   (inst_p1),
        .creg   (creg),
        .result (core_res),
        .flags  (core_flags)
    );

    // Stage 2: result/flags register; carry register commits as the op moves into this stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            alu_out <= '0;
            flags   <= '0;
            creg    <= 1'b0;
        end else begin
            if (s2_adv) vld_p2 <= vld_p1;
            if (s2_adv && vld_p1) begin
                alu_out <= core_res;
                flags   <= core_flags;
                if (loads_creg(inst_p1)) begin
                    creg <= core_flags[FLAG_C];
                end else if (clears_creg(inst_p1)) begin
                    creg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: 4-bit instance with table vectors and a result scoreboard, 8-bit instance for shifts.
// Expected values follow the ALU_SAT_EN build option when it is defined.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] op_a, op_b, inst, alu_out, flags;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] op_a8, op_b8, alu_out8;
    logic [3:0] inst8, flags8;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .inst(inst), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .flags(flags)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op_a(op_a8), .op_b(op_b8), .inst(inst8), .out_valid(out_valid8),
        .out_ready(out_ready8), .alu_out(alu_out8), .flags(flags8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ins;
        logic [3:0] res;
        logic [3:0] flg;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flg;
    } exp_t;

    localparam int NV = 21;
    vec_t vecs[NV];
    vec_t bp[4];
    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   beat_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", alu_out);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("beat%0d_out", beat_idx), alu_out, mon_e.res);
                check($sformatf("beat%0d_flags", beat_idx), flags, mon_e.flg);
                beat_idx++;
            end
        end
    end

    task automatic send(input vec_t v, output int waits);
        exp_t e;
        in_valid = 1'b1;
        op_a = v.a;
        op_b = v.b;
        inst = v.ins;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 50);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%0b required=1", in_ready);
        end else begin
            e.res = v.res;
            e.flg = v.flg;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] ins, input logic [7:0] res, input logic [3:0] flg);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b1;
        op_a8 = a;
        op_b8 = b;
        inst8 = ins;
        @(negedge clk);
        check({name, "_in_ready"}, in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid8 && n < 10);
        check({name, "_valid"}, out_valid8, 1);
        check({name, "_out"}, alu_out8, res);
        check({name, "_flags"}, flags8, flg);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int w;
        vecs[0]  = '{4'd3,  4'd6,  4'b0010, 4'd2,  4'b0000};
        vecs[1]  = '{4'd6,  4'd8,  4'b1000, 4'd14, 4'b0100};
`ifdef ALU_SAT_EN
        vecs[2]  = '{4'd15, 4'd1,  4'b1000, 4'd15, 4'b0110};
`else
        vecs[2]  = '{4'd15, 4'd1,  4'b1000, 4'd0,  4'b1010};
`endif
        vecs[3]  = '{4'd0,  4'd0,  4'b1010, 4'd1,  4'b0000};
        vecs[4]  = '{4'd0,  4'd0,  4'b1011, 4'd0,  4'b1000};
`ifdef ALU_SAT_EN
        vecs[5]  = '{4'd0,  4'd1,  4'b1001, 4'd0,  4'b1010};
`else
        vecs[5]  = '{4'd0,  4'd1,  4'b1001, 4'd15, 4'b0110};
`endif
        vecs[6]  = '{4'd0,  4'd0,  4'b1111, 4'd0,  4'b1000};
`ifdef ALU_SAT_EN
        vecs[7]  = '{4'd12, 4'd7,  4'b1000, 4'd15, 4'b0110};
`else
        vecs[7]  = '{4'd12, 4'd7,  4'b1000, 4'd3,  4'b0010};
`endif
        vecs[8]  = '{4'd7,  4'd1,  4'b1000, 4'd8,  4'b0101};
        vecs[9]  = '{4'd5,  4'd3,  4'b0001, 4'd7,  4'b0000};
        vecs[10] = '{4'd5,  4'd3,  4'b0111, 4'd9,  4'b0100};
        vecs[11] = '{4'd10, 4'd0,  4'b0100, 4'd5,  4'b0000};
        vecs[12] = '{4'd12, 4'd10, 4'b0110, 4'd7,  4'b0000};
        vecs[13] = '{4'd5,  4'd5,  4'b1001, 4'd0,  4'b1000};
        vecs[14] = '{4'd8,  4'd1,  4'b1001, 4'd7,  4'b0001};
`ifdef ALU_SAT_EN
        vecs[15] = '{4'd3,  4'd5,  4'b1011, 4'd0,  4'b1010};
`else
        vecs[15] = '{4'd3,  4'd5,  4'b1011, 4'd14, 4'b0110};
`endif
        vecs[16] = '{4'd5,  4'd2,  4'b1011, 4'd2,  4'b0000};
        vecs[17] = '{4'd3,  4'd1,  4'b1100, 4'd6,  4'b0000};
        vecs[18] = '{4'd8,  4'd1,  4'b1110, 4'd12, 4'b0100};
        vecs[19] = '{4'd9,  4'd4,  4'b1101, 4'd0,  4'b1000};
        vecs[20] = '{4'd9,  4'd5,  4'b1110, 4'd15, 4'b0100};

        bp[0] = '{4'd1,  4'd2,  4'b1000, 4'd3,  4'b0000};
        bp[1] = '{4'd4,  4'd1,  4'b0001, 4'd5,  4'b0000};
        bp[2] = '{4'd15, 4'd1,  4'b0011, 4'd14, 4'b0100};
        bp[3] = '{4'd7,  4'd12, 4'b0010, 4'd4,  4'b0000};

        rst_n = 1'b0;
        in_valid = 1'b0; op_a = '0; op_b = '0; inst = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; op_a8 = '0; op_b8 = '0; inst8 = '0; out_ready8 = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_flags", flags, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // First beat: latency and drain-fall timing
        @(posedge clk);
        #1;
        in_valid = 1'b1; op_a = vecs[0].a; op_b = vecs[0].b; inst = vecs[0].ins;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1);
        sb.push_back('{vecs[0].res, vecs[0].flg});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge_n", out_valid, 0);
        @(negedge clk);
        check("lat_edge_n1", out_valid, 1);
        @(negedge clk);
        check("drain_fall", out_valid, 0);

        @(posedge clk);
        #1;
        for (int i = 1; i < NV; i++) begin
            send(vecs[i], w);
            check($sformatf("tput%0d", i), w, 1);
        end
        drain("table_drained");

        // Backpressure: two beats fill the pipe, the third must stall
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(bp[0], w);
        send(bp[1], w);
        in_valid = 1'b1; op_a = bp[2].a; op_b = bp[2].b; inst = bp[2].ins;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready%0d", k), in_ready, 0);
            check($sformatf("bp_valid%0d", k), out_valid, 1);
            check($sformatf("bp_hold_out%0d", k), alu_out, bp[0].res);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(bp[2], w);
        send(bp[3], w);
        drain("bp_drained");

        // Reset with two beats in flight; the first sets Creg before reset
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send('{4'd15, 4'd1, 4'b1000, 4'd0, 4'b1010}, w);
        send('{4'd1, 4'd2, 4'b0001, 4'd3, 4'b0000}, w);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_alu_out", alu_out, 0);
        check("midrst_flags", flags, 0);
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send('{4'd1, 4'd1, 4'b1010, 4'd2, 4'b0000}, w);
        drain("midrst_drained");

        run8("sra_90_2",  8'h90, 8'd2, 4'b1110, 8'hE4, 4'b0100);
        run8("shl_90_9",  8'h90, 8'd9, 4'b1100, 8'h00, 4'b1000);
        run8("shr_81_0",  8'h81, 8'd0, 4'b1101, 8'h81, 4'b0100);
        run8("shr_81_8",  8'h81, 8'd8, 4'b1101, 8'h00, 4'b1000);
        run8("sra_90_15", 8'h90, 8'd15, 4'b1110, 8'hFF, 4'b0100);
        run8("shl_81_7",  8'h81, 8'd7, 4'b1100, 8'h80, 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
